dmem_bus_arbiter: RTL

//  Two-requester arbiter sharing the single data-memory/GPIO slave port of the RV32I core.

---
 rtl/dmem_arb_pkg.sv | 38 +++
 rtl/arb_watchdog.sv | 42 ++++
 rtl/dmem_bus_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory bus arbiter.
// Optional watchdog feature is enabled with the DMEM_ARB_TIMEOUT_EN macro.
package dmem_arb_pkg;

   // Arbiter FSM states: idle, or serving requester 0 / requester 1.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY0 = 2'd1,
      BUSY1 = 2'd2
   } arb_state_e;

   // Identifier of one of the two requesters.
   typedef logic req_id_t;

   // Default number of BUSY cycles without s_ack before the watchdog aborts.
   localparam int DEF_TIMEOUT_CYC = 255;

   // Counter width able to hold 0 .. cyc-1 (at least one bit).
   function automatic int wdog_cnt_w(input int cyc);
      return (cyc <= 2) ? 1 : $clog2(cyc);
   endfunction

   // Round-robin pick: a lone requester wins outright; on a tie the
   // requester that was not granted last time wins.
   function automatic req_id_t rr_pick(input logic req0, input logic req1,
                                       input req_id_t last);
      req_id_t pick;
      if (req0 && req1) begin
         pick = ~last;
      end else if (req1) begin
         pick = 1'b1;
      end else begin
         pick = 1'b0;
      end
      return pick;
   endfunction

endpackage

// File: rtl/arb_watchdog.sv
// BUSY-cycle watchdog for the data-memory bus arbiter.
// Only instantiated when DMEM_ARB_TIMEOUT_EN is defined.
// The count restarts on every grant and advances on each BUSY cycle that
// ends without s_ack; 'terminal' flags the last allowed cycle and 'expire'
// flags an abort (terminal cycle with no s_ack, so a late ack still wins).
module arb_watchdog
   import dmem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic busy,
   input  logic s_ack,
   output logic terminal,
   output logic expire
);

   localparam int               CNT_W    = wdog_cnt_w(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_reg;

   // Count completed BUSY cycles of the current grant; clear on each new grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (start) begin
         cnt_reg <= '0;
      end else if (busy && !s_ack && !terminal) begin
         cnt_reg <= cnt_reg + CNT_ONE;
      end
   end

   // The cycle in which cnt_reg reaches TIMEOUT_CYC-1 is the TIMEOUT_CYC-th BUSY cycle.
   assign terminal = busy && (cnt_reg == LAST_CNT);
   assign expire   = terminal && !s_ack;

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the single data-memory/GPIO
// slave port. Requester 0 is the core load/store path, requester 1 the
// debug/program loader. A grant is held until the slave acknowledges.
// Define DMEM_ARB_TIMEOUT_EN to add the BUSY watchdog (abort with mK_err).
module dmem_bus_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)
(
   input  logic                clk,
   input  logic                rst,
   // requester 0: core load/store path
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_be,
   output logic                m0_ack,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_err,
   // requester 1: debug / program loader
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_be,
   output logic                m1_ack,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_err,
   // shared slave port
   output logic                s_req,
   output logic                s_we,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_be,
   input  logic                s_ack,
   input  logic [DATA_W-1:0]   s_rdata
);

   localparam int BE_W = DATA_W / 8;

   // A timeout of zero cycles is meaningless; stop elaboration early.
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("dmem_bus_arbiter: TIMEOUT_CYC must be at least 1");
   end

   // ------------------------------------------------------------------
   // Requester ports gathered into arrays so per-requester logic is uniform
   // ------------------------------------------------------------------
   logic               req_vec   [2];
   logic               we_vec    [2];
   logic [ADDR_W-1:0]  addr_vec  [2];
   logic [DATA_W-1:0]  wdata_vec [2];
   logic [BE_W-1:0]    be_vec    [2];
   logic               busy_vec  [2];
   logic               ack_vec   [2];
   logic               err_vec   [2];
   logic [DATA_W-1:0]  rdata_vec [2];

   assign req_vec[0]   = m0_req;
   assign req_vec[1]   = m1_req;
   assign we_vec[0]    = m0_we;
   assign we_vec[1]    = m1_we;
   assign addr_vec[0]  = m0_addr;
   assign addr_vec[1]  = m1_addr;
   assign wdata_vec[0] = m0_wdata;
   assign wdata_vec[1] = m1_wdata;
   assign be_vec[0]    = m0_be;
   assign be_vec[1]    = m1_be;

   // ------------------------------------------------------------------
   // FSM and round-robin pointer
   // ------------------------------------------------------------------
   arb_state_e state_reg;
   req_id_t    last_grant_reg;   // in BUSYk this is k, i.e. the current owner
   req_id_t    grant_next;
   logic       any_req;
   logic       busy;
   logic       start;
   logic       terminal;         // last BUSY cycle allowed by the watchdog
   logic       expire;           // watchdog abort this cycle
   logic       done;             // current transfer completes this cycle

   assign any_req    = req_vec[0] || req_vec[1];
   assign grant_next = rr_pick(req_vec[0], req_vec[1], last_grant_reg);
   assign busy       = (state_reg == BUSY0) || (state_reg == BUSY1);
   assign start      = (state_reg == IDLE) && any_req;
   assign done       = busy && (s_ack || expire);

   // Arbitrate in IDLE, then hold the grant until the slave (or watchdog) finishes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;   // requester 0 wins the first tie
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  last_grant_reg <= grant_next;
                  state_reg      <= grant_next ? BUSY1 : BUSY0;
               end
            end
            BUSY0, BUSY1: begin
               // A requester dropping req mid-transfer is ignored; only the
               // slave ack (or a watchdog abort) ends the grant.
               if (done) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Optional watchdog
   // ------------------------------------------------------------------
`ifdef DMEM_ARB_TIMEOUT_EN
   arb_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .busy     (busy),
      .s_ack    (s_ack),
      .terminal (terminal),
      .expire   (expire)
   );
`else
   // Without the watchdog a hung slave keeps the grant forever.
   assign terminal = 1'b0;
   assign expire   = 1'b0;
   logic unused_start;
   assign unused_start = start;
`endif

   // ------------------------------------------------------------------
   // Slave-side payload mux
   // ------------------------------------------------------------------
   // s_req is dropped on the watchdog's terminal cycle using only registered
   // state, so there is no combinational path from s_ack back to s_req.
   assign s_req = busy && !terminal;

   // Route the owner's payload to the slave; everything is zero while idle.
   always_comb begin
      s_we    = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_be    = '0;
      if (busy) begin
         s_we    = we_vec[last_grant_reg];
         s_addr  = addr_vec[last_grant_reg];
         s_wdata = wdata_vec[last_grant_reg];
         s_be    = be_vec[last_grant_reg];
      end
   end

   // ------------------------------------------------------------------
   // Requester-side responses
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      localparam arb_state_e OWN_STATE = (gi == 0) ? BUSY0 : BUSY1;

      assign busy_vec[gi] = (state_reg == OWN_STATE);

      // Ack and error are strobes for the owner only; the other side sees 0.
      assign ack_vec[gi] = busy_vec[gi] && (s_ack || expire);
      assign err_vec[gi] = busy_vec[gi] && expire;

      // Read data is visible only during a genuine slave ack; an aborted or
      // absent ack presents zero so no stale data leaks through.
      assign rdata_vec[gi] = (busy_vec[gi] && s_ack) ? s_rdata : '0;
   end

   assign m0_ack   = ack_vec[0];
   assign m1_ack   = ack_vec[1];
   assign m0_err   = err_vec[0];
   assign m1_err   = err_vec[1];
   assign m0_rdata = rdata_vec[0];
   assign m1_rdata = rdata_vec[1];

endmodule
